// File: rtl/qed_pkg.sv
// Shared opcode constants, field positions, FSM state type and the duplicate
// remapping function for the QED instruction duplicator.
package qed_pkg;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [31:0] QED_NOP = 32'h0000_0013;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int IMM_LSB = 20;

    typedef enum logic {ST_ORIG, ST_DUP} qed_state_e;

    function automatic logic qed_eligible(input logic [6:0] opc);
        return (opc == OPC_OPIMM) || (opc == OPC_OP) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_LUI);
    endfunction

    // x0 must keep meaning "zero" in the duplicate stream.
    function automatic logic [4:0] qed_reg_add(input logic [4:0] r, input logic [4:0] off);
        return (r == 5'd0) ? 5'd0 : 5'(r + off);
    endfunction

    function automatic logic [31:0] qed_remap(input logic [31:0] instr,
                                              input logic [4:0]  reg_off,
                                              input logic [11:0] mem_off);
        logic [31:0] o;
        logic [11:0] imm;
        logic [6:0]  opc;
        logic        use_rd, use_rs1, use_rs2;
        o   = instr;
        imm = 12'd0;
        opc = instr[6:0];
        use_rd  = (opc == OPC_OP) || (opc == OPC_OPIMM) || (opc == OPC_LOAD) || (opc == OPC_LUI);
        use_rs1 = (opc == OPC_OP) || (opc == OPC_OPIMM) || (opc == OPC_LOAD) || (opc == OPC_STORE);
        use_rs2 = (opc == OPC_OP) || (opc == OPC_STORE);
        if (use_rd)
            o[RD_LSB +: 5] = qed_reg_add(instr[RD_LSB +: 5], reg_off);
        if (use_rs1)
            o[RS1_LSB +: 5] = qed_reg_add(instr[RS1_LSB +: 5], reg_off);
        if (use_rs2)
            o[RS2_LSB +: 5] = qed_reg_add(instr[RS2_LSB +: 5], reg_off);
        if (opc == OPC_LOAD) begin
            imm = instr[IMM_LSB +: 12] + mem_off;
            o[IMM_LSB +: 12] = imm;
        end
        if (opc == OPC_STORE) begin
            imm = {instr[31:25], instr[11:7]} + mem_off;
            o[31:25] = imm[11:5];
            o[11:7]  = imm[4:0];
        end
        return o;
    endfunction

endpackage

// File: rtl/qed_fifo.sv
// Synchronous show-ahead FIFO holding recorded instructions awaiting replay.
module qed_fifo
    import qed_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/qed_dup_buffer.sv
// QED duplicator between fetch and decode: forwards originals, records eligible
// ones, and replays them as register/memory-remapped duplicates in batches.
module qed_dup_buffer
    import qed_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          REG_OFFSET = 16,
    parameter logic [11:0] MEM_OFFSET = 12'h400,
    parameter logic [31:0] NOP        = QED_NOP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     exec_dup,
    input  logic                     stall_IF,
    input  logic [31:0]              ifu_qed_instruction,
    output logic                     qed_rdy,
    output logic [31:0]              qed_ifu_instruction,
    output logic                     vld_out,
    output logic [$clog2(DEPTH):0]   dup_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    qed_state_e   r_state;
    logic [31:0]  r_instr_p0;
    logic         r_vld_p0;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_go_dup;
    logic [31:0]   w_head;
    logic [31:0]   w_dup_instr;
    logic [CW-1:0] w_count;

    assign w_go_dup = w_full || (ena && exec_dup && !w_empty);
    assign qed_rdy  = (r_state == ST_ORIG) && !w_full && !(exec_dup && ena && !w_empty);
    assign w_push   = (r_state == ST_ORIG) && ena && !stall_IF && qed_rdy &&
                      qed_eligible(ifu_qed_instruction[6:0]);
    assign w_pop    = (r_state == ST_DUP) && !stall_IF && !w_empty;
    assign w_dup_instr = qed_remap(w_head, 5'(REG_OFFSET), MEM_OFFSET);

    qed_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (ifu_qed_instruction),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Output stage: one register between the fetch/replay mux and decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ORIG;
            r_instr_p0 <= NOP;
            r_vld_p0   <= 1'b0;
        end else if (stall_IF) begin
            r_vld_p0 <= 1'b0;
        end else begin
            case (r_state)
                ST_ORIG: begin
                    if (w_go_dup) begin
                        r_state  <= ST_DUP;
                        r_vld_p0 <= 1'b0;
                    end else begin
                        r_instr_p0 <= ifu_qed_instruction;
                        r_vld_p0   <= 1'b1;
                    end
                end
                ST_DUP: begin
                    r_instr_p0 <= w_dup_instr;
                    r_vld_p0   <= !w_empty;
                    if (w_count <= CW'(1))
                        r_state <= ST_ORIG;
                end
                default: r_state <= ST_ORIG;
            endcase
        end
    end

    assign qed_ifu_instruction = r_instr_p0;
    assign vld_out             = r_vld_p0;
    assign dup_count           = w_count;

endmodule
